bfu_ct_addsub: RTL and testbench
================================

Name: bfu_ct_addsub

Overview:
- Downstream companion of `modular_mul` inside the Cooley-Tukey butterfly unit.
- Takes the upper operand A when the multiplier is issued, delay-matches it to the multiplier latency, then combines it with the product P = W·B mod Q.
- Produces X = A+P mod Q and Y = A−P mod Q, with an optional ×2⁻¹ (halving) step for INTT.
- Counts emitted butterflies and flags the end of each NTT stage.

Parameters:
- DW, 12, coefficient width.
- Q, 3329, modulus; Q < 2^DW, Q odd.
- MUL_LAT, 4, cycles from `modular_mul` operand capture to valid `P_out`; ≥ 1.
- BFLY_PER_STAGE, 128, butterflies per NTT stage; power of two.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush of the valid pipe and the counter.
- in_valid  in  1  A_in/in_half are valid; the same-cycle multiplier operands are valid.
- in_half  in  1  apply ×2⁻¹ mod Q to both outputs (INTT last stage).
- A_in  in  DW  upper butterfly operand, < Q.
- P_in  in  DW  product from `modular_mul` `P_out`, < Q.
- out_valid  in/out: out  1  X_out/Y_out valid.
- X_out  out  DW  (A+P)[·2⁻¹] mod Q.
- Y_out  out  DW  (A−P)[·2⁻¹] mod Q.
- stage_done  out  1  one-cycle pulse coincident with the BFLY_PER_STAGE-th out_valid.
- bfly_cnt  out  $clog2(BFLY_PER_STAGE)  butterflies emitted in the current stage.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, X_out=0, Y_out=0, stage_done=0, bfly_cnt=0, all delay-line valid bits=0. Data delay registers are also cleared.
- Delay line:
  - MUL_LAT-deep shift register of {in_valid, in_half, A_in}, advancing every cycle. No stall and no backpressure, matching the free-running multiplier.
  - At tap MUL_LAT, A_d/half_d/v_d align with P_in.
- Output stage: one register. Total latency from in_valid to out_valid is MUL_LAT+1 cycles; throughput is 1 per cycle.
- Arithmetic, with DW+1-bit intermediates:
  - s = A_d+P_in; if s ≥ Q then s −= Q.
  - d = A_d−P_in; if the borrow is set then d += Q.
- Halving, when half_d=1, applied to each of s and d:
  - even: h = v>>1
  - odd: h = (v+Q)>>1, computed at DW+1 bits.
- When v_d=0: X_out/Y_out hold their previous values and out_valid=0.
- Counter: increments on each out_valid and wraps BFLY_PER_STAGE−1 → 0. stage_done=1 in the same cycle as the out_valid that causes the wrap.
- clr=1: next edge zeroes the delay-line valid bits, out_valid, stage_done and bfly_cnt. X_out/Y_out hold. A clr asserted together with in_valid drops that input.
- Back-to-back transactions: every in_valid produces exactly one out_valid, in order; no bubbles are inserted.
- Out-of-range inputs (≥ Q): output value unspecified. No X propagation is allowed into the control path.
- Reset mid-operation drops all in-flight transactions. The first output after rst deassertion occurs MUL_LAT+1 cycles after the first in_valid.

Decomposition:
- Shared package `cfntt_pkg` holds:
  - the DW and Q constants;
  - a `coef_t` typedef of logic[DW-1:0];
  - the `MUL_LAT` constant, so that `modular_mul` and this block agree on latency.
- One natural sub-module: `mod_addsub_half`, combinational (A, P, half) → (X, Y), reusable by the GS butterfly. The delay line, output register and counter stay in the top block.

Test Plan:
- A_in=0xBB4 (2996) with in_valid; P_in=0x020 (32, which is 0xBB4·0xBC1 mod Q) driven MUL_LAT cycles later → after MUL_LAT+1 cycles, X_out=0xBD4 (3028), Y_out=0xB94 (2964), out_valid=1 for exactly one cycle.
- Sum wrap: A=3000, P=1000 → X=671, Y=2000.
- Difference borrow: A=5, P=10, in_half=0 → X=15, Y=3324 (0xCFC).
- Same operands with in_half=1 → X=1672, Y=1662. The bench checks 2·X ≡ 15 and 2·Y ≡ 3324 mod Q.
- 128 consecutive in_valid beats → 128 consecutive out_valid beats; stage_done is high only on the 128th; bfly_cnt returns to 0; the 129th beat gives bfly_cnt=1 and no stage_done.
- Reset/flush handling:
  - rst pulsed low with 2 transactions in flight → out_valid stays 0 with no spurious output; all outputs read 0.
  - clr with 3 transactions in flight, then a new beat → only the new beat emerges, with bfly_cnt=1 after it.

Source files
------------

// File: rtl/cfntt_pkg.sv
// Shared constants and types for the Cooley-Tukey / Gentleman-Sande NTT datapath.
// The multiplier latency lives here so that modular_mul and its companions cannot
// disagree on it.
package cfntt_pkg;

  localparam int DW      = 12;
  localparam int Q       = 3329;
  localparam int MUL_LAT = 4;

  typedef logic [DW-1:0] coef_t;

endpackage

// File: rtl/mod_addsub_half.sv
// Combinational modular add/subtract with optional halving (multiply by 2^-1 mod Q).
// Shared between the CT and GS butterflies.
module mod_addsub_half
  import cfntt_pkg::*;
(
  input  coef_t a,
  input  coef_t p,
  input  logic  half,
  output coef_t x,
  output coef_t y
);

  localparam logic [DW:0] Q_W = (DW+1)'(Q);

  logic [DW:0] s_raw, s_red, d_raw, d_red;
  logic [DW:0] s_hv, d_hv;

  // Halving an odd residue: add Q first so the value becomes even, then shift.
  // v < Q < 2^DW, so v + Q fits in DW+1 bits.
  function automatic logic [DW:0] halve(input logic [DW:0] v);
    if (v[0]) return (v + Q_W) >> 1;
    else      return v >> 1;
  endfunction

  // Reduce sum and difference into [0, Q), then optionally halve both.
  always_comb begin
    s_raw = {1'b0, a} + {1'b0, p};
    s_red = (s_raw >= Q_W) ? (s_raw - Q_W) : s_raw;
    d_raw = {1'b0, a} - {1'b0, p};
    d_red = d_raw[DW] ? (d_raw + Q_W) : d_raw;
    s_hv  = half ? halve(s_red) : s_red;
    d_hv  = half ? halve(d_red) : d_red;
    x     = s_hv[DW-1:0];
    y     = d_hv[DW-1:0];
  end

endmodule

// File: rtl/bfu_ct_addsub.sv
// Back half of the CT butterfly: delays A to line up with the multiplier product,
// forms (A+P, A-P) mod Q with optional halving, registers the result and counts
// butterflies per NTT stage.
module bfu_ct_addsub
  import cfntt_pkg::*;
#(
  parameter int BFLY_PER_STAGE = 128
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              in_valid,
  input  logic                              in_half,
  input  coef_t                             A_in,
  input  coef_t                             P_in,
  output logic                              out_valid,
  output coef_t                             X_out,
  output coef_t                             Y_out,
  output logic                              stage_done,
  output logic [$clog2(BFLY_PER_STAGE)-1:0] bfly_cnt
);

  localparam int             CW       = $clog2(BFLY_PER_STAGE);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BFLY_PER_STAGE - 1);

  logic [MUL_LAT-1:0] v_pipe;
  logic [MUL_LAT-1:0] h_pipe;
  coef_t              a_pipe [MUL_LAT];

  logic  v_d, h_d;
  coef_t a_d;
  coef_t x_nxt, y_nxt;

  // Free-running delay line matching the multiplier latency; clr only kills the valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_pipe <= '0;
      h_pipe <= '0;
      for (int i = 0; i < MUL_LAT; i++) a_pipe[i] <= '0;
    end else begin
      v_pipe[0] <= in_valid & ~clr;
      h_pipe[0] <= in_half;
      a_pipe[0] <= A_in;
      for (int i = 1; i < MUL_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1] & ~clr;
        h_pipe[i] <= h_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
      end
    end
  end

  assign v_d = v_pipe[MUL_LAT-1];
  assign h_d = h_pipe[MUL_LAT-1];
  assign a_d = a_pipe[MUL_LAT-1];

  mod_addsub_half u_addsub (
    .a    (a_d),
    .p    (P_in),
    .half (h_d),
    .x    (x_nxt),
    .y    (y_nxt)
  );

  // Output register and stage counter; stage_done marks the beat that wraps the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      X_out      <= '0;
      Y_out      <= '0;
      stage_done <= 1'b0;
      bfly_cnt   <= '0;
    end else if (clr) begin
      out_valid  <= 1'b0;
      stage_done <= 1'b0;
      bfly_cnt   <= '0;
    end else begin
      out_valid  <= v_d;
      stage_done <= 1'b0;
      if (v_d) begin
        X_out <= x_nxt;
        Y_out <= y_nxt;
        if (bfly_cnt == CNT_LAST) begin
          bfly_cnt   <= '0;
          stage_done <= 1'b1;
        end else begin
          bfly_cnt <= bfly_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bfu_ct_addsub.sv
// Scoreboard bench for bfu_ct_addsub: the stimulus side pushes expected results
// computed with plain modular arithmetic; a negedge monitor pops and compares.
module tb_bfu_ct_addsub;
  import cfntt_pkg::*;

  localparam int BPS = 128;
  localparam int CW  = $clog2(BPS);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_half = 1'b0;
  coef_t         A_in = '0;
  coef_t         P_in = '0;
  logic          out_valid;
  coef_t         X_out, Y_out;
  logic          stage_done;
  logic [CW-1:0] bfly_cnt;

  bfu_ct_addsub #(.BFLY_PER_STAGE(BPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_half    (in_half),
    .A_in       (A_in),
    .P_in       (P_in),
    .out_valid  (out_valid),
    .X_out      (X_out),
    .Y_out      (Y_out),
    .stage_done (stage_done),
    .bfly_cnt   (bfly_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int x;
    int y;
    int s;
    int d;
    bit h;
    int cnt;
    bit sd;
  } exp_t;

  exp_t q[$];
  int   pmap[int];
  int   cyc = 0;
  int   model_cnt = 0;
  int   last_x = 0;
  int   last_y = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input int a, input int p, input bit h);
    exp_t e;
    int inv2;
    inv2  = (Q + 1) / 2;
    e.s   = (a + p) % Q;
    e.d   = (a - p + Q) % Q;
    e.h   = h;
    e.x   = h ? (e.s * inv2) % Q : e.s;
    e.y   = h ? (e.d * inv2) % Q : e.d;
    e.due = 0;
    e.cnt = 0;
    e.sd  = 1'b0;
    return e;
  endfunction

  // One clock of stimulus; P for a beat is scheduled MUL_LAT cycles later.
  task automatic step(input bit v, input bit h, input int a, input int p, input bit c);
    exp_t e;
    in_valid = v;
    in_half  = h;
    A_in     = a[DW-1:0];
    clr      = c;
    if (v && !c) pmap[cyc + MUL_LAT] = p;
    if (pmap.exists(cyc)) begin
      P_in = pmap[cyc][DW-1:0];
      pmap.delete(cyc);
    end else begin
      P_in = DW'($urandom_range(0, Q - 1));
    end
    if (c) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      model_cnt = 0;
    end else if (v) begin
      e = model(a, p, h);
      model_cnt = (model_cnt + 1) % BPS;
      e.cnt = model_cnt;
      e.sd  = (model_cnt == 0);
      e.due = cyc + MUL_LAT + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_x"}, int'(X_out), 0);
    check({tag, "_y"}, int'(Y_out), 0);
    check({tag, "_stage_done"}, int'(stage_done), 0);
    check({tag, "_bfly_cnt"}, int'(bfly_cnt), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    check_zero_outputs("rst");
    q.delete();
    pmap.delete();
    model_cnt = 0;
    last_x = 0;
    last_y = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1;
  endtask

  // Monitor: compare each emitted butterfly; between outputs, X/Y must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_out: got out_valid=1 X=%0d Y=%0d expected no output (cycle %0d)",
                   X_out, Y_out, cyc);
        end else begin
          e = q.pop_front();
          check("latency", cyc, e.due);
          check("x_out", int'(X_out), e.x);
          check("y_out", int'(Y_out), e.y);
          check("bfly_cnt", int'(bfly_cnt), e.cnt);
          check("stage_done", int'(stage_done), int'(e.sd));
          if (e.h) begin
            check("half_2x", (2 * int'(X_out)) % Q, e.s);
            check("half_2y", (2 * int'(Y_out)) % Q, e.d);
          end
          last_x = e.x;
          last_y = e.y;
        end
      end else begin
        check("hold_x", int'(X_out), last_x);
        check("hold_y", int'(Y_out), last_y);
        check("stage_done_idle", int'(stage_done), 0);
      end
    end
  end

  initial begin
    int a, p;
    bit v, h, c;

    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("init");
    rst = 1'b1;

    // Directed vectors: product case, sum wrap, borrow, halving.
    step(1'b1, 1'b0, 2996, 32, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 3000, 1000, 1'b0);
    step(1'b1, 1'b0, 5, 10, 1'b0);
    step(1'b1, 1'b1, 5, 10, 1'b0);
    step(1'b1, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b1, Q - 1, 0, 1'b0);
    step(1'b1, 1'b0, 0, Q - 1, 1'b0);
    idle(8);

    // Full stage: counter from zero, stage_done on beat 128, wrap to 1 on beat 129.
    step(1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < BPS + 1; i++)
      step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), 1'b0);
    idle(8);

    // Reset with two beats in flight: nothing may come out afterwards.
    step(1'b1, 1'b0, 100, 200, 1'b0);
    step(1'b1, 1'b0, 300, 400, 1'b0);
    do_reset();
    idle(8);

    // Flush with three beats in flight plus one dropped alongside clr.
    step(1'b1, 1'b0, 11, 22, 1'b0);
    step(1'b1, 1'b0, 33, 44, 1'b0);
    step(1'b1, 1'b0, 55, 66, 1'b0);
    step(1'b1, 1'b0, 77, 88, 1'b1);
    step(1'b1, 1'b0, 1234, 2345, 1'b0);
    idle(8);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      h = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 49) == 0);
      a = $urandom_range(0, Q - 1);
      p = $urandom_range(0, Q - 1);
      step(v, h, a, p, c);
    end
    idle(MUL_LAT + 4);

    check("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
